// File: rtl/bytestream_defs.sv
// Constants shared by the bytestream FT232, UART and FIFO blocks.
package bytestream_defs;

  localparam int unsigned BS_WIDTH      = 8;
  localparam int unsigned OVF_CNT_WIDTH = 8;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [OVF_CNT_WIDTH-1:0] sat_inc(input logic [OVF_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + OVF_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/bytestream_fifo_mem.sv
// Simple dual-port byte RAM: synchronous write, asynchronous read (LUTRAM).
module bytestream_fifo_mem
  import bytestream_defs::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [BS_WIDTH-1:0]   wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [BS_WIDTH-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [BS_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bytestream_fifo.sv
// Elastic byte buffer between a non-backpressured producer strobe and a
// valid/consume consumer; drops and counts bytes that arrive while full.
module bytestream_fifo
  import bytestream_defs::*;
#(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BS_WIDTH-1:0]      in_data,
  input  logic                     in_produce,
  output logic [BS_WIDTH-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_consume,
  output logic [DEPTH_LOG2:0]      level,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [OVF_CNT_WIDTH-1:0] overflow_count,
  input  logic                     overflow_clr
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [BS_WIDTH-1:0] head;
  logic                empty_c;
  logic                full_c;
  logic                push_c;
  logic                pop_c;
  logic                drop_c;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                   (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign pop_c   = out_consume && !empty_c;
  assign push_c  = in_produce && (!full_c || pop_c);
  assign drop_c  = in_produce && full_c && !pop_c;

  // When full with a pop, the write lands on the head slot that is being read out this cycle.
  bytestream_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (push_c && reset),
    .waddr(wr_ptr[DEPTH_LOG2-1:0]),
    .wdata(in_data),
    .raddr(rd_ptr[DEPTH_LOG2-1:0]),
    .rdata(head)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Set beats clear when a drop coincides with overflow_clr.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else if (drop_c) begin
      overflow       <= 1'b1;
      overflow_count <= overflow_clr ? OVF_CNT_WIDTH'(1) : sat_inc(overflow_count);
    end else if (overflow_clr) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
    end
  end

  assign level       = wr_ptr - rd_ptr;
  assign almost_full = (level >= PTR_W'(AFULL_THRESH));
  assign out_valid   = !empty_c;
  assign out_data    = empty_c ? '0 : head;

endmodule

// File: tb/tb_bytestream_fifo.sv
// Directed-vector bench for bytestream_fifo with DEPTH_LOG2=4, AFULL_THRESH=12.
module tb_bytestream_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_produce;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_consume;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic [7:0] overflow_count;
  logic       overflow_clr;

  int vectors    = 0;
  int miscompares = 0;

  bytestream_fifo #(
    .DEPTH_LOG2  (4),
    .AFULL_THRESH(12)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_produce    (in_produce),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_consume   (out_consume),
    .level         (level),
    .almost_full   (almost_full),
    .overflow      (overflow),
    .overflow_count(overflow_count),
    .overflow_clr  (overflow_clr)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) begin
      in_data = 8'(i); in_produce = 1'b1;
      tick();
    end
    in_produce = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_produce = 1'b1; in_data = 8'hEE;
    out_consume = 1'b0; overflow_clr = 1'b0;
    tick(); tick();
    reset = 1'b1; in_produce = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0 || out_data !== 8'h00 ||
        almost_full !== 1'b0 || overflow_count !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_idle: got valid=%b level=%0d ovf=%b data=%h afull=%b cnt=%0d, expected 0 0 0 00 0 0",
               out_valid, level, overflow, out_data, almost_full, overflow_count);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got valid=%b level=%0d, expected 0 0", out_valid, level);
    end
  endtask

  task automatic test_single();
    in_data = 8'hA5; in_produce = 1'b1;
    tick();
    in_produce = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 5'd1) begin
      miscompares++;
      $display("FAIL single_push: got valid=%b data=%h level=%0d, expected 1 a5 1", out_valid, out_data, level);
    end
    out_consume = 1'b1;
    tick();
    out_consume = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || level !== 5'd0 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL single_pop: got valid=%b level=%0d data=%h, expected 0 0 00", out_valid, level, out_data);
    end
    out_consume = 1'b1;
    tick();
    out_consume = 1'b0;
    vectors++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL consume_empty: got level=%0d valid=%b, expected 0 0", level, out_valid);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i); in_produce = 1'b1;
      tick();
      vectors++;
      if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 12)) begin
        miscompares++;
        $display("FAIL fill_level: got level=%0d afull=%b, expected %0d %b", level, almost_full, i + 1, (i + 1 >= 12));
      end
    end
    in_produce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (out_data !== 8'(i) || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_pop_a: got data=%h valid=%b, expected %h 1", out_data, out_valid, 8'(i));
      end
      out_consume = 1'b1;
      tick();
    end
    out_consume = 1'b0;
    vectors++;
    if (level !== 5'd8 || almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_mid_level: got level=%0d afull=%b, expected 8 0", level, almost_full);
    end
    for (int i = 16; i < 24; i++) begin
      in_data = 8'(i); in_produce = 1'b1;
      tick();
    end
    in_produce = 1'b0;
    vectors++;
    if (level !== 5'd16) begin
      miscompares++;
      $display("FAIL wrap_refill: got level=%0d, expected 16", level);
    end
    for (int i = 8; i < 24; i++) begin
      vectors++;
      if (out_data !== 8'(i) || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_drain: got data=%h valid=%b, expected %h 1", out_data, out_valid, 8'(i));
      end
      out_consume = 1'b1;
      tick();
    end
    out_consume = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL wrap_empty: got valid=%b level=%0d, expected 0 0", out_valid, level);
    end
  endtask

  task automatic test_overflow();
    fill_ramp(16);
    vectors++;
    if (overflow !== 1'b0 || overflow_count !== 8'd0) begin
      miscompares++;
      $display("FAIL ovf_none_at_full: got ovf=%b cnt=%0d, expected 0 0", overflow, overflow_count);
    end
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hAA; in_produce = 1'b1;
      tick();
      vectors++;
      if (overflow !== 1'b1 || overflow_count !== 8'(i + 1) || level !== 5'd16) begin
        miscompares++;
        $display("FAIL ovf_drop: got ovf=%b cnt=%0d level=%0d, expected 1 %0d 16", overflow, overflow_count, level, i + 1);
      end
    end
    overflow_clr = 1'b1;
    tick();
    in_produce = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || overflow_count !== 8'd1) begin
      miscompares++;
      $display("FAIL ovf_clr_vs_drop: got ovf=%b cnt=%0d, expected 1 1", overflow, overflow_count);
    end
    tick();
    overflow_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || overflow_count !== 8'd0) begin
      miscompares++;
      $display("FAIL ovf_clr: got ovf=%b cnt=%0d, expected 0 0", overflow, overflow_count);
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (out_data !== 8'(i)) begin
        miscompares++;
        $display("FAIL ovf_contents: got %h expected %h", out_data, 8'(i));
      end
      out_consume = 1'b1;
      tick();
    end
    out_consume = 1'b0;
  endtask

  task automatic test_back_to_back();
    fill_ramp(16);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (out_data !== ((i < 16) ? 8'(i) : 8'h55)) begin
        miscompares++;
        $display("FAIL b2b_head: got %h expected %h", out_data, (i < 16) ? 8'(i) : 8'h55);
      end
      in_data = 8'h55; in_produce = 1'b1; out_consume = 1'b1;
      tick();
      vectors++;
      if (level !== 5'd16 || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_level: got level=%0d ovf=%b, expected 16 0", level, overflow);
      end
    end
    in_produce = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (out_data !== 8'h55 || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_drain: got data=%h valid=%b, expected 55 1", out_data, out_valid);
      end
      tick();
    end
    out_consume = 1'b0;
    vectors++;
    if (level !== 5'd0 || overflow_count !== 8'd0) begin
      miscompares++;
      $display("FAIL b2b_end: got level=%0d cnt=%0d, expected 0 0", level, overflow_count);
    end
  endtask

  task automatic test_reset_midstream();
    fill_ramp(5);
    vectors++;
    if (level !== 5'd5) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got level=%0d expected 5", level);
    end
    reset = 1'b0; in_data = 8'h99; in_produce = 1'b1; out_consume = 1'b1;
    tick();
    reset = 1'b1; in_produce = 1'b0; out_consume = 1'b0;
    vectors++;
    if (level !== 5'd0 || out_valid !== 1'b0 || overflow_count !== 8'd0 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mid: got level=%0d valid=%b cnt=%0d data=%h, expected 0 0 0 00",
               level, out_valid, overflow_count, out_data);
    end
    in_data = 8'h3C; in_produce = 1'b1;
    tick();
    in_produce = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || level !== 5'd1) begin
      miscompares++;
      $display("FAIL rst_mid_new: got valid=%b data=%h level=%0d, expected 1 3c 1", out_valid, out_data, level);
    end
    out_consume = 1'b1;
    tick();
    out_consume = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_mid_drain: got valid=%b level=%0d, expected 0 0", out_valid, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
